// File: rtl/piso_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_serial_tx
// Description : Parallel-in/serial-out transmitter with valid/ready intake,
//               framing flags and a configurable idle gap between frames.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serial_tx #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             q,
    output logic             q_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int                 c_cnt_w    = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [3:0]         c_gap_last = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_nxt;
    logic [WIDTH-1:0]   w_shifted;
    logic [3:0]         r_gap_cnt;
    logic [3:0]         w_gap_nxt;
    logic               w_out_bit;
    logic               w_last_bit;
    logic               w_accept;
    logic               r_q;
    logic               r_q_valid;
    logic               r_frame_start;
    logic               r_frame_end;
    logic               r_busy;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
            assign w_out_bit = w_shreg_nxt[WIDTH-1];
        end else begin : g_lsb_first
            assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
            assign w_out_bit = w_shreg_nxt[0];
        end
    endgenerate

    assign w_last_bit = (r_state == ST_SHIFT) && (r_cnt == c_cnt_last);
    // With no gap, the last-bit cycle also accepts the next word so frames abut.
    assign din_ready  = reset && ((r_state == ST_IDLE) || (w_last_bit && (GAP == 0)));
    assign w_accept   = din_valid && din_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shreg_nxt = r_shreg;
        w_gap_nxt   = r_gap_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                    w_shreg_nxt = din;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHIFT: begin
                if (w_last_bit) begin
                    if (w_accept) begin
                        w_shreg_nxt = din;
                        w_cnt_nxt   = '0;
                    end else if (GAP > 0) begin
                        w_state_nxt = ST_GAP;
                        w_gap_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_shreg_nxt = w_shifted;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-state so the first bit appears one cycle after accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_shreg       <= '0;
            r_gap_cnt     <= '0;
            r_q           <= 1'b0;
            r_q_valid     <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_shreg       <= w_shreg_nxt;
            r_gap_cnt     <= w_gap_nxt;
            r_q           <= (w_state_nxt == ST_SHIFT) && w_out_bit;
            r_q_valid     <= (w_state_nxt == ST_SHIFT);
            r_frame_start <= (w_state_nxt == ST_SHIFT) && (w_cnt_nxt == '0);
            r_frame_end   <= (w_state_nxt == ST_SHIFT) && (w_cnt_nxt == c_cnt_last);
            r_busy        <= (w_state_nxt != ST_IDLE);
        end
    end

    assign q           = r_q;
    assign q_valid     = r_q_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_piso_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serial_tx
// Description : Bench for piso_serial_tx: three configurations (MSB/GAP=1,
//               LSB/GAP=1, MSB/GAP=0), directed vector table plus random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serial_tx;

    localparam int c_w      = 8;
    localparam int c_idle_t = 1000;

    logic       clk;
    logic       reset;
    logic [2:0] dv;
    logic [7:0] din_a [3];
    logic [2:0] rdy, qo, qv, fs, fe, bsy;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        piso_serial_tx #(
            .WIDTH    (c_w),
            .MSB_FIRST((g == 1) ? 0 : 1),
            .GAP      ((g == 2) ? 0 : 1)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .din        (din_a[g]),
            .din_valid  (dv[g]),
            .din_ready  (rdy[g]),
            .q          (qo[g]),
            .q_valid    (qv[g]),
            .frame_start(fs[g]),
            .frame_end  (fe[g]),
            .busy       (bsy[g])
        );
    end

    initial clk = 1'b0;
    always #2 clk = ~clk;

    typedef struct {
        int         dut;
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic [5:0] exp;   // {din_ready, q_valid, q, frame_start, frame_end, busy}
    } vec_t;

    vec_t       tbl[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         t    [3];  // cycles since accept edge (1 = first bit cycle)
    logic [7:0] word [3];

    task automatic add(input int d, input logic r, input logic v, input logic [7:0] x,
                       input logic [5:0] e);
        vec_t rec;
        rec.dut = d; rec.rst = r; rec.v = v; rec.d = x; rec.exp = e;
        tbl.push_back(rec);
    endtask

    // Reference: outputs follow purely from elapsed time since the accepted word.
    function automatic logic [5:0] model_out(input int g);
        int   gap;
        bit   msb;
        int   idx;
        logic in_frame, bit_v, bsy_m, rdy_m;
        gap      = (g == 2) ? 0 : 1;
        msb      = (g != 1);
        in_frame = (t[g] >= 1) && (t[g] <= c_w);
        idx      = t[g] - 1;
        bit_v    = in_frame ? (msb ? word[g][c_w-1-idx] : word[g][idx]) : 1'b0;
        bsy_m    = (t[g] >= 1) && (t[g] <= c_w + gap);
        rdy_m    = reset && (!bsy_m || (gap == 0 && t[g] == c_w));
        return {rdy_m, in_frame, bit_v, in_frame && idx == 0, in_frame && idx == c_w - 1, bsy_m};
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step(input int tg, input logic [5:0] texp, input bit use_t);
        logic [5:0] em [3];
        logic [5:0] act;
        #1;
        for (int g = 0; g < 3; g++) begin
            em[g] = model_out(g);
            act   = {rdy[g], qv[g], qo[g], fs[g], fe[g], bsy[g]};
            checks++;
            if (act !== em[g]) begin
                errors++;
                $display("FAIL model dut%0d cycle %0d: got %b expected %b", g, cyc, act, em[g]);
            end
            if (use_t && g == tg) begin
                checks++;
                if (act !== texp) begin
                    errors++;
                    $display("FAIL vector dut%0d cycle %0d: got %b expected %b", g, cyc, act, texp);
                end
            end
        end
        @(posedge clk);
        for (int g = 0; g < 3; g++) begin
            if (!reset) t[g] = c_idle_t;
            else if (dv[g] && em[g][5]) begin
                word[g] = din_a[g];
                t[g]    = 1;
            end else if (t[g] < c_idle_t) t[g]++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic frame_rows(input int d, input logic [7:0] x, input logic [5:0] first,
                              input logic [7:0] bits, input logic [5:0] tail);
        add(d, 1, 1, x, 6'b100000);
        for (int i = 0; i < 8; i++) begin
            logic [5:0] e;
            e = {2'b01, bits[7-i], i == 0, i == 7, 1'b1};
            add(d, 1, 0, x, e);
        end
        add(d, 1, 0, x, tail);
        add(d, 1, 0, x, 6'b100000);
        if (first != 6'b011101 && first != 6'b010101) add(d, 1, 0, x, first);
    endtask

    initial begin
        reset = 1'b0;
        dv    = 3'b001;
        for (int g = 0; g < 3; g++) begin
            din_a[g] = 8'hFF;
            t[g]     = c_idle_t;
            word[g]  = '0;
        end

        // Reset held with a valid word offered: nothing captured.
        add(0, 0, 1, 8'hFF, 6'b000000);
        add(0, 0, 1, 8'hFF, 6'b000000);
        add(0, 1, 0, 8'hFF, 6'b100000);
        add(0, 1, 0, 8'hFF, 6'b100000);
        // 8'hA5 MSB-first: 1,0,1,0,0,1,0,1 then one gap cycle.
        frame_rows(0, 8'hA5, 6'b011101, 8'b10100101, 6'b000001);
        // 8'h1E LSB-first: 0,1,1,1,1,0,0,0.
        frame_rows(1, 8'h1E, 6'b010101, 8'b01111000, 6'b000001);
        // GAP=0 back-to-back 8'hFF then 8'h00 with valid held.
        add(2, 1, 1, 8'hFF, 6'b100000);
        add(2, 1, 1, 8'h00, 6'b011101);
        for (int i = 0; i < 6; i++) add(2, 1, 1, 8'h00, 6'b011001);
        add(2, 1, 1, 8'h00, 6'b111011);
        add(2, 1, 0, 8'h00, 6'b010101);
        for (int i = 0; i < 6; i++) add(2, 1, 0, 8'h00, 6'b010001);
        add(2, 1, 0, 8'h00, 6'b110011);
        add(2, 1, 0, 8'h00, 6'b100000);
        // din changes to 8'h00 mid-frame of 8'hFF: ignored.
        add(0, 1, 1, 8'hFF, 6'b100000);
        add(0, 1, 0, 8'hFF, 6'b011101);
        add(0, 1, 0, 8'hFF, 6'b011001);
        for (int i = 0; i < 5; i++) add(0, 1, 1, 8'h00, 6'b011001);
        add(0, 1, 1, 8'h00, 6'b011011);
        add(0, 1, 0, 8'h00, 6'b000001);
        add(0, 1, 0, 8'h00, 6'b100000);
        // Reset mid-frame of 8'hA5, then a clean 8'h3C frame.
        add(0, 1, 1, 8'hA5, 6'b100000);
        add(0, 1, 0, 8'hA5, 6'b011101);
        add(0, 1, 0, 8'hA5, 6'b010001);
        add(0, 1, 0, 8'hA5, 6'b011001);
        add(0, 0, 0, 8'hA5, 6'b010001);
        frame_rows(0, 8'h3C, 6'b010101, 8'b00111100, 6'b000001);

        @(posedge clk);
        for (int g = 0; g < 3; g++) t[g] = c_idle_t;
        @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst;
            for (int g = 0; g < 3; g++) begin
                dv[g]    = (g == tbl[i].dut) ? tbl[i].v : 1'b0;
                din_a[g] = (g == tbl[i].dut) ? tbl[i].d : 8'h00;
            end
            step(tbl[i].dut, tbl[i].exp, 1'b1);
        end

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 63) != 0);
            for (int g = 0; g < 3; g++) begin
                dv[g]    = ($urandom_range(0, 3) != 0);
                din_a[g] = 8'($urandom);
            end
            step(0, 6'b000000, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
